sxr_pll_reset_ctrl: RTL and testbench

Reset and lock supervisor for the core clock PLL, clocked from the 50 MHz board reference clock.
- Upstream side: drives the PLL reset pulse (`pll_rst`).
- Downstream side: consumes the PLL `locked` flag, filters it, and releases the RISC core reset only after lock has been stable.
- Recovery: re-sequences automatically on lock loss or lock timeout, and latches a sticky failure after a bounded number of retries.

---
 rtl/sxr_pll_pkg.sv | 22 ++
 rtl/sxr_sync2.sv | 23 ++
 rtl/sxr_pll_reset_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sxr_pll_reset_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sxr_pll_pkg.sv
// Shared types and default timing constants for the PLL reset/lock supervisor.
package sxr_pll_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 256;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_RELEASE_DELAY       = 8;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sxr_sync2.sv
// Two-flop synchronizer with a selectable asynchronous reset value.
module sxr_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/sxr_pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses pll_rst, qualifies locked,
// releases core_rst, and retries on timeout up to a sticky failure.
module sxr_pll_reset_ctrl
  import sxr_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned RELEASE_DELAY       = DEF_RELEASE_DELAY,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       pll_ok,
  output logic       lock_lost,
  output logic       lock_fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned CNT_MAX = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                          max_u(LOCK_STABLE_CYCLES, RELEASE_DELAY));
  localparam int unsigned CW = $clog2(CNT_MAX) + 1;
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES) + 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST     = CW'(RELEASE_DELAY - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

  logic w_rst_int;
  logic w_locked_s;

  pll_state_e r_state;
  pll_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_stable;
  logic [1:0]    r_retry;
  logic [1:0]    w_retry_nxt;
  logic          w_restart;

  logic w_pll_rst_nxt;
  logic w_core_rst_nxt;
  logic w_pll_ok_nxt;
  logic w_lock_lost_nxt;
  logic w_lock_fail_nxt;

  logic r_pll_rst;
  logic r_core_rst;
  logic r_pll_ok;
  logic r_lock_lost;
  logic r_lock_fail;

  // Reset asserts immediately and releases two refclk edges after rst falls.
  sxr_sync2 #(.RST_VAL(1'b1)) u_rst_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (1'b0),
    .o_q   (w_rst_int)
  );

  sxr_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .i_clk (refclk),
    .i_rst (w_rst_int),
    .i_d   (locked),
    .o_q   (w_locked_s)
  );

  always_ff @(posedge refclk or posedge w_rst_int) begin
    if (w_rst_int) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_stable    <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_core_rst  <= 1'b1;
      r_pll_ok    <= 1'b0;
      r_lock_lost <= 1'b0;
      r_lock_fail <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      // Counters restart on every state entry, including a soft re-entry of PLL_RST.
      if (w_restart) begin
        r_cnt    <= '0;
        r_stable <= '0;
      end else begin
        if ((r_state == ST_PLL_RST) || (r_state == ST_WAIT_LOCK) || (r_state == ST_RELEASE)) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_state == ST_WAIT_LOCK) begin
          r_stable <= w_locked_s ? (r_stable + 1'b1) : '0;
        end
      end
      r_pll_rst   <= w_pll_rst_nxt;
      r_core_rst  <= w_core_rst_nxt;
      r_pll_ok    <= w_pll_ok_nxt;
      r_lock_lost <= w_lock_lost_nxt;
      r_lock_fail <= w_lock_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_locked_s && (r_stable == STABLE_LAST)) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt = ST_PLL_RST;
            w_retry_nxt = r_retry + 2'd1;
          end
        end
      end
      ST_RELEASE: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_PLL_RST;
        end else if (r_cnt == REL_LAST) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!w_locked_s) w_state_nxt = ST_PLL_RST;
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
      end
    endcase
    if (soft_rst_req && (r_state != ST_FAIL)) begin
      w_state_nxt = ST_PLL_RST;
      w_retry_nxt = '0;
    end
    w_restart = (w_state_nxt != r_state) || (soft_rst_req && (r_state != ST_FAIL));
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_pll_rst_nxt   = (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAIL);
    w_core_rst_nxt  = (w_state_nxt != ST_RUN);
    w_pll_ok_nxt    = (w_state_nxt == ST_RUN);
    w_lock_lost_nxt = (r_state == ST_RUN) && !w_locked_s && !soft_rst_req;
    w_lock_fail_nxt = (w_state_nxt == ST_FAIL);
  end

  assign pll_rst   = r_pll_rst;
  assign core_rst  = r_core_rst;
  assign pll_ok    = r_pll_ok;
  assign lock_lost = r_lock_lost;
  assign lock_fail = r_lock_fail;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_sxr_pll_reset_ctrl.sv
// Self-checking bench for sxr_pll_reset_ctrl with reduced timing parameters.
module tb_sxr_pll_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       pll_rst;
  logic       core_rst;
  logic       pll_ok;
  logic       lock_lost;
  logic       lock_fail;
  logic [1:0] retry_cnt;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  sxr_pll_reset_ctrl #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .RELEASE_DELAY       (2),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .core_rst     (core_rst),
    .pll_ok       (pll_ok),
    .lock_lost    (lock_lost),
    .lock_fail    (lock_fail),
    .retry_cnt    (retry_cnt)
  );

  always #5 refclk = ~refclk;

  assign obs = {pll_rst, core_rst, pll_ok, lock_lost, lock_fail, retry_cnt};

  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    int          adv;
    logic        lk;
    logic        sr;
    logic [6:0]  exp;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[15];

  function automatic logic [6:0] ov(input int pr, input int cr, input int ok,
                                    input int ll, input int lf, input int rc);
    return {pr[0], cr[0], ok[0], ll[0], lf[0], rc[1:0]};
  endfunction

  function automatic logic sel_val(input int sel);
    return (sel == 0) ? pll_rst : core_rst;
  endfunction

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [6:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got nothing expected an entry");
    end else begin
      e = sb_q.pop_front();
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (pll_rst core_rst pll_ok lock_lost lock_fail retry[1:0])",
                 e.name, obs, e.exp);
      end
    end
  endtask

  task automatic expect_now(input string name, input logic [6:0] exp);
    sb_push(name, exp);
    sb_check();
  endtask

  // Steps until the selected output reaches lvl; n is the number of edges taken.
  task automatic wait_sig(input string name, input int sel, input logic lvl,
                          input int maxc, output int n);
    n = 0;
    while (sel_val(sel) !== lvl && n < maxc) begin
      step();
      n++;
    end
    if (sel_val(sel) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: got no transition within %0d cycles required one", name, maxc);
    end
  endtask

  task automatic set_vec(input int i, input string name, input int adv, input logic lk,
                         input logic sr, input logic [6:0] exp);
    vecs[i].name = name;
    vecs[i].adv  = adv;
    vecs[i].lk   = lk;
    vecs[i].sr   = sr;
    vecs[i].exp  = exp;
  endtask

  task automatic do_reset();
    locked       = 1'b0;
    soft_rst_req = 1'b0;
    #2 rst = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int falls, hi_len, since_fall;
    int widths[3];
    int retries[3];
    logic prev;

    set_vec(0,  "sync_window",     2,  1'b0, 1'b0, ov(1,1,0,0,0,0));
    set_vec(1,  "pll_rst_phase",   3,  1'b0, 1'b0, ov(1,1,0,0,0,0));
    set_vec(2,  "wait_lock_entry", 1,  1'b0, 1'b0, ov(0,1,0,0,0,0));
    set_vec(3,  "wait_lock_idle",  4,  1'b0, 1'b0, ov(0,1,0,0,0,0));
    set_vec(4,  "lock_qualify",    11, 1'b1, 1'b0, ov(0,1,0,0,0,0));
    set_vec(5,  "run_entry",       1,  1'b1, 1'b0, ov(0,0,1,0,0,0));
    set_vec(6,  "lock_drop_sync1", 1,  1'b0, 1'b0, ov(0,0,1,0,0,0));
    set_vec(7,  "lock_drop_sync2", 1,  1'b1, 1'b0, ov(0,0,1,0,0,0));
    set_vec(8,  "lock_lost_edge",  1,  1'b1, 1'b0, ov(1,1,0,1,0,0));
    set_vec(9,  "relock_pll_rst",  3,  1'b1, 1'b0, ov(1,1,0,0,0,0));
    set_vec(10, "relock_wait",     1,  1'b1, 1'b0, ov(0,1,0,0,0,0));
    set_vec(11, "relock_qualify",  9,  1'b1, 1'b0, ov(0,1,0,0,0,0));
    set_vec(12, "relock_run",      1,  1'b1, 1'b0, ov(0,0,1,0,0,0));
    set_vec(13, "soft_from_run",   1,  1'b1, 1'b1, ov(1,1,0,0,0,0));
    set_vec(14, "soft_resequence", 4,  1'b1, 1'b0, ov(0,1,0,0,0,0));

    // Power-on reset state, then table-driven bring-up / lock-loss / soft request.
    repeat (3) step();
    expect_now("reset_state", ov(1,1,0,0,0,0));
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      locked       = vecs[i].lk;
      soft_rst_req = vecs[i].sr;
      sb_push(vecs[i].name, vecs[i].exp);
      repeat (vecs[i].adv) step();
      sb_check();
    end
    soft_rst_req = 1'b0;

    // Glitchy lock: 6 high, 1 low, then steady; release 12 edges after the final rise.
    do_reset();
    rst = 1'b0;
    wait_sig("glitch_pll_rst_fall", 0, 1'b0, 50, n);
    locked = 1'b1;
    repeat (6) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    wait_sig("glitch_core_release", 1, 1'b0, 100, n);
    chk_int("glitch_release_latency", n, 12);
    expect_now("glitch_run_state", ov(0,0,1,0,0,0));

    // Timeout path to FAIL with locked held low.
    do_reset();
    rst = 1'b0;
    falls = 0; hi_len = 0; since_fall = 0; prev = 1'b1;
    for (int c = 0; c < 400 && !lock_fail; c++) begin
      step();
      if (pll_rst && !prev) hi_len = 1;
      else if (pll_rst) hi_len++;
      if (prev && !pll_rst) begin
        if (falls < 3) begin
          widths[falls]  = hi_len;
          retries[falls] = int'(retry_cnt);
        end
        falls++;
        since_fall = 0;
      end else begin
        since_fall++;
      end
      prev = pll_rst;
    end
    chk_int("fail_reached", int'(lock_fail), 1);
    chk_int("fail_pll_rst_phases", falls, 3);
    chk_int("retry_phase0", retries[0], 0);
    chk_int("retry_phase1", retries[1], 1);
    chk_int("retry_phase2", retries[2], 2);
    chk_int("pll_rst_width_phase1", widths[1], 4);
    chk_int("pll_rst_width_phase2", widths[2], 4);
    chk_int("fail_entry_latency", since_fall, 32);
    expect_now("fail_state", ov(1,1,0,0,1,2));
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    repeat (3) step();
    expect_now("fail_ignores_soft", ov(1,1,0,0,1,2));
    #3 rst = 1'b1;
    #1;
    expect_now("async_rst_clears_fail", ov(1,1,0,0,0,0));

    // soft_rst_req coinciding with stable completion, after one consumed retry.
    do_reset();
    rst = 1'b0;
    wait_sig("prio_first_fall", 0, 1'b0, 50, n);
    wait_sig("prio_retry_rise", 0, 1'b1, 60, n);
    chk_int("prio_retry_before", int'(retry_cnt), 1);
    wait_sig("prio_second_fall", 0, 1'b0, 50, n);
    locked = 1'b1;
    repeat (9) step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    expect_now("prio_soft_wins", ov(1,1,0,0,0,0));
    wait_sig("prio_resequence", 1, 1'b0, 60, n);
    expect_now("prio_run_after", ov(0,0,1,0,0,0));

    // Asynchronous reset between edges while in RUN.
    do_reset();
    locked = 1'b1;
    rst = 1'b0;
    wait_sig("async_bringup", 1, 1'b0, 60, n);
    expect_now("async_pre_run", ov(0,0,1,0,0,0));
    #3 rst = 1'b1;
    #1;
    expect_now("async_rst_mid_run", ov(1,1,0,0,0,0));
    rst = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
